// File: rtl/reset_req_gen.sv
// Turns a raw, bouncing front-panel button into one fixed-length reset request per press.
// Optional watchdog-triggered requests are compiled in when RESET_REQ_WATCHDOG_EN is defined.
module reset_req_gen #(
   parameter int               CNT_W           = 20,
   parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd500000,
   parameter logic [CNT_W-1:0] PULSE_CYCLES    = 20'd16
`ifdef RESET_REQ_WATCHDOG_EN
   ,
   parameter logic [31:0]      WDOG_CYCLES     = 32'd100000000
`endif
) (
   input  logic sysclk,
   input  logic reset,
   input  logic button,
`ifdef RESET_REQ_WATCHDOG_EN
   input  logic wdog_kick,
   output logic wdog_fired,
`endif
   output logic rst_req,
   output logic btn_level,
   output logic busy
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] DEB_PRESS = 2'd1;
   localparam logic [1:0] PULSE     = 2'd2;
   localparam logic [1:0] WAIT_REL  = 2'd3;

   localparam logic [CNT_W-1:0] DEB_LAST   = DEBOUNCE_CYCLES - 1'b1;
   localparam logic [CNT_W-1:0] PULSE_LAST = PULSE_CYCLES - 1'b1;

   logic             sync_q;
   logic             button_s;
   logic [1:0]       state;
   logic [1:0]       state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             btn_level_n;

`ifdef RESET_REQ_WATCHDOG_EN
   localparam logic [31:0] WDOG_LAST = WDOG_CYCLES - 32'd1;

   logic [31:0] wdog_cnt;
   logic        wdog_pulse;
   logic        wdog_expire;

   assign wdog_expire = ((state == IDLE) || (state == DEB_PRESS)) && !wdog_kick &&
                        (wdog_cnt == WDOG_LAST);
`endif

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      btn_level_n = btn_level;
      case (state)
         IDLE: begin
            if (button_s) begin
               state_n = DEB_PRESS;
               cnt_n   = '0;
            end
         end
         DEB_PRESS: begin
            if (!button_s) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == DEB_LAST) begin
               state_n     = PULSE;
               cnt_n       = '0;
               btn_level_n = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PULSE: begin
            if (cnt == PULSE_LAST) begin
               state_n = WAIT_REL;
               cnt_n   = '0;
`ifdef RESET_REQ_WATCHDOG_EN
               // A watchdog pulse with the button up has no release to wait for.
               if (wdog_pulse && !button_s) begin
                  state_n     = IDLE;
                  btn_level_n = 1'b0;
               end
`endif
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            if (button_s) begin
               cnt_n = '0;
            end else if (cnt == DEB_LAST) begin
               state_n     = IDLE;
               cnt_n       = '0;
               btn_level_n = 1'b0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
      endcase
`ifdef RESET_REQ_WATCHDOG_EN
      if (wdog_expire) begin
         state_n = PULSE;
         cnt_n   = '0;
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         sync_q    <= 1'b0;
         button_s  <= 1'b0;
         state     <= IDLE;
         cnt       <= '0;
         btn_level <= 1'b0;
         rst_req   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         sync_q    <= button;
         button_s  <= sync_q;
         state     <= state_n;
         cnt       <= cnt_n;
         btn_level <= btn_level_n;
         rst_req   <= (state_n == PULSE);
         busy      <= (state_n != IDLE);
      end
   end

`ifdef RESET_REQ_WATCHDOG_EN
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         wdog_cnt   <= '0;
         wdog_pulse <= 1'b0;
         wdog_fired <= 1'b0;
      end else begin
         // Held at zero while a request is in progress or being released.
         if (wdog_kick || (state_n == PULSE) || (state == PULSE) || (state == WAIT_REL)) begin
            wdog_cnt <= '0;
         end else begin
            wdog_cnt <= wdog_cnt + 32'd1;
         end
         if ((state_n == PULSE) && (state != PULSE)) begin
            wdog_pulse <= wdog_expire;
         end
         if (wdog_expire) begin
            wdog_fired <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_reset_req_gen.sv
// Self-checking bench for reset_req_gen: vector table plus directed multi-cycle sequences.
module tb_reset_req_gen;

   typedef struct {
      logic btn;
      logic req;
      logic lvl;
      logic busy;
   } vec_t;

   vec_t vecs[$];

   logic sysclk = 1'b0;
   logic reset  = 1'b1;
   logic button = 1'b0;
   logic rst_req;
   logic btn_level;
   logic busy;
`ifdef RESET_REQ_WATCHDOG_EN
   logic wdog_kick = 1'b1;
   logic wdog_fired;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 sysclk = ~sysclk;

   reset_req_gen #(
      .CNT_W          (20),
      .DEBOUNCE_CYCLES(20'd4),
      .PULSE_CYCLES   (20'd3)
`ifdef RESET_REQ_WATCHDOG_EN
      ,
      .WDOG_CYCLES    (32'd20)
`endif
   ) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .button    (button),
`ifdef RESET_REQ_WATCHDOG_EN
      .wdog_kick (wdog_kick),
      .wdog_fired(wdog_fired),
`endif
      .rst_req   (rst_req),
      .btn_level (btn_level),
      .busy      (busy)
   );

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic seg(input int n, input logic b, input logic r, input logic l, input logic y);
      vec_t v;
      v.btn  = b;
      v.req  = r;
      v.lvl  = l;
      v.busy = y;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic step(input logic b);
      button = b;
      @(posedge sysclk);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      button = 1'b0;
      repeat (2) @(posedge sysclk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic rel_pat [9];
      int   req_cnt;

      repeat (3) @(posedge sysclk);
      #1;
      check("reset rst_req", rst_req, 1'b0);
      check("reset btn_level", btn_level, 1'b0);
      check("reset busy", busy, 1'b0);
`ifdef RESET_REQ_WATCHDOG_EN
      check("reset wdog_fired", wdog_fired, 1'b0);
`endif
      reset = 1'b0;

      // Clean press held 20 cycles: request after edges 7..9, idle 4 cycles after button_s falls.
      seg(2, 1, 0, 0, 0);
      seg(4, 1, 0, 0, 1);
      seg(3, 1, 1, 1, 1);
      seg(11, 1, 0, 1, 1);
      seg(5, 0, 0, 1, 1);
      seg(3, 0, 0, 0, 0);
      // Back-to-back presses separated by 5 low cycles: two 3-cycle pulses.
      seg(2, 1, 0, 0, 0);
      seg(4, 1, 0, 0, 1);
      seg(3, 1, 1, 1, 1);
      seg(1, 1, 0, 1, 1);
      seg(5, 0, 0, 1, 1);
      seg(2, 1, 0, 0, 0);
      seg(4, 1, 0, 0, 1);
      seg(3, 1, 1, 1, 1);
      seg(1, 1, 0, 1, 1);
      seg(5, 0, 0, 1, 1);
      seg(3, 0, 0, 0, 0);
      // Bounce 1,1,0,1,1,0,0...: aborted presses, busy only during DEB_PRESS.
      seg(1, 1, 0, 0, 0);
      seg(1, 1, 0, 0, 0);
      seg(1, 0, 0, 0, 1);
      seg(1, 1, 0, 0, 1);
      seg(1, 1, 0, 0, 0);
      seg(1, 0, 0, 0, 1);
      seg(1, 0, 0, 0, 1);
      seg(3, 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].btn);
         check($sformatf("vec%0d rst_req", i), rst_req, vecs[i].req);
         check($sformatf("vec%0d btn_level", i), btn_level, vecs[i].lvl);
         check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      end

      // Release bounce: a high sample in WAIT_REL restarts the 4-sample release count.
      repeat (10) step(1'b1);
      check("relb in WAIT_REL busy", busy, 1'b1);
      check("relb in WAIT_REL rst_req", rst_req, 1'b0);
      rel_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int e = 11; e <= 19; e++) begin
         step(rel_pat[e - 11]);
         check($sformatf("relb edge%0d busy", e), busy, (e != 19));
         check($sformatf("relb edge%0d btn_level", e), btn_level, (e != 19));
      end
      repeat (3) step(1'b0);

      // Reset during the second request cycle clears everything asynchronously.
      repeat (7) step(1'b1);
      check("midrst first req cycle", rst_req, 1'b1);
      step(1'b1);
      check("midrst second req cycle", rst_req, 1'b1);
      #1;
      reset  = 1'b1;
      button = 1'b0;
      #1;
      check("midrst async rst_req", rst_req, 1'b0);
      check("midrst async btn_level", btn_level, 1'b0);
      check("midrst async busy", busy, 1'b0);
      repeat (2) @(posedge sysclk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step(1'b0);
         check($sformatf("post-reset cyc%0d rst_req", i), rst_req, 1'b0);
         check($sformatf("post-reset cyc%0d busy", i), busy, 1'b0);
      end

`ifdef RESET_REQ_WATCHDOG_EN
      // No kick: counter reaches 19 after edge 19, request after edges 20..22, then straight to IDLE.
      wdog_kick = 1'b0;
      do_reset();
      for (int e = 1; e <= 26; e++) begin
         step(1'b0);
         check($sformatf("wdog edge%0d rst_req", e), rst_req, (e >= 20 && e <= 22));
         check($sformatf("wdog edge%0d busy", e), busy, (e >= 20 && e <= 22));
         check($sformatf("wdog edge%0d wdog_fired", e), wdog_fired, (e >= 20));
      end
      // Kick every 10 cycles: no request in 200 cycles.
      do_reset();
      req_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         wdog_kick = (i % 10 == 0);
         step(1'b0);
         if (rst_req) req_cnt++;
      end
      wdog_kick = 1'b1;
      check("wdog kicked no request", (req_cnt == 0), 1'b1);
      check("wdog kicked wdog_fired", wdog_fired, 1'b0);
`else
      req_cnt = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
